amp_cfg_scheduler: RTL and testbench
====================================

AMP_CFG_SCHEDULER -- requirements
Module: amp_cfg_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023, max clkin cycles allowed in any wait state.
REQ-002 SHALL have parameter ARM_CYC, default 2, cycles that din/enable are held stable with start=0 before start rises.
REQ-003 SHALL have port clkin input 1: the single clock (25 MHz); the serializer runs on the same clock.
REQ-004 SHALL have port rst input 1: synchronous, active-high reset.
REQ-005 SHALL have port req input 1: one-cycle request to configure.
REQ-006 SHALL have port mode input 2: 01 = 1595 load only, 10 = 595 load only, 11 = 1595 then 595, 00 = no-op.
REQ-007 SHALL have port dac_in0..dac_in3 input 32 each: 1595 words {ub,ua}, {ux,uc}, {ib,ia}, {ix,ic}.
REQ-008 SHALL have port rly_in input 64: 595 bytes, LSB first: UA,UB,UC,UX,IA,IB,IC,IX.
REQ-009 SHALL have port config_done input 1: done flag from the serializer.
REQ-010 SHALL have ports start, ld1595_en, ld595_en output 1 each, and din0..din3 output 32 each, all driving the serializer.
REQ-011 SHALL have port busy output 1: high whenever the state is not IDLE.
REQ-012 SHALL have port done output 1: one-cycle pulse when a sequence completes without error.
REQ-013 SHALL have port err_timeout output 1: sticky timeout flag, cleared by rst or by an accepted req.

Function
REQ-014 SHALL have FSM states IDLE, ARM, GO, REL, NEXT and FIN; a phase register records whether the current load is 1595 or 595.
REQ-015 In IDLE, when req=1 and mode!=00: SHALL capture mode, dac_in* and rly_in, clear err_timeout, and enter ARM for the first phase (1595 if mode[0], else 595).
REQ-016 In IDLE, req with mode=00 SHALL be ignored, with no done pulse.
REQ-017 1595 phase: din0..3 = captured dac_in0..3; ld1595_en=1; ld595_en=0.
REQ-018 595 phase: dinK = {byte(2K+1), 8'h00, byte(2K), 8'h00}; ld595_en=1; ld1595_en=0.
REQ-019 din and enable outputs SHALL be registered and stable from ARM entry through REL exit.
REQ-020 ARM: start=0 for exactly ARM_CYC cycles, then enter GO.
REQ-021 GO: start=1; when config_done=1, enter REL.
REQ-022 REL: start=0; when config_done=0, enter NEXT.
REQ-023 NEXT: if phase=1595 and mode=11, switch to the 595 phase and re-enter ARM; otherwise enter FIN.
REQ-024 FIN: pulse done for 1 cycle, drive ld*_en=0, return to IDLE.
REQ-025 A wait counter SHALL clear on entry to GO and on entry to REL, and increment each cycle spent in GO or REL.
REQ-026 If the wait counter reaches TIMEOUT_CYC, SHALL set err_timeout, force start=0 and ld*_en=0, and go to IDLE with no done pulse.
REQ-027 A req while busy SHALL set a one-deep pending flag and capture its mode and data; further reqs while pending overwrite that capture.
REQ-028 The pending request SHALL start on the cycle after FIN, and SHALL be dropped on timeout.
REQ-029 start SHALL never be high in two phases without an intervening low of at least ARM_CYC+1 cycles.

Reset
REQ-030 On rst=1 at a clock edge, SHALL set: state IDLE; start, ld1595_en, ld595_en, busy, done and err_timeout = 0; din0..3 = 0; pending = 0; counter = 0.
REQ-031 rst SHALL take effect mid-sequence, dropping start on the next edge.

Verification
REQ-032 mode=01, dac_in0=32'h1234_5678, serializer model asserting done 40 cycles after start -> din0=32'h12345678, ld1595_en=1; start rises 3 cycles after req; one done pulse.
REQ-033 mode=10, rly_in=64'h...0201 -> din0=32'h0200_0100, ld595_en=1, ld1595_en=0 throughout.
REQ-034 mode=11 -> two full start high/low cycles, 1595 first, then 595; single done pulse after the second REL.
REQ-035 config_done held 0 -> err_timeout=1 after 1024 GO cycles; start=0; no done; next req clears err_timeout.
REQ-036 req during GO of a mode=01 sequence -> second sequence begins the cycle after FIN with the new data; exactly two done pulses.
REQ-037 rst asserted during GO -> start=0 and all outputs at reset values on the next edge.

Source files
------------

// File: rtl/amp_cfg_scheduler.sv
// rtl/amp_cfg_scheduler.sv - sequences 1595/595 loads through the shared serializer
module amp_cfg_scheduler #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int ARM_CYC     = 2
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  mode,
    input  logic [31:0] dac_in0,
    input  logic [31:0] dac_in1,
    input  logic [31:0] dac_in2,
    input  logic [31:0] dac_in3,
    input  logic [63:0] rly_in,
    input  logic        config_done,
    output logic        start,
    output logic        ld1595_en,
    output logic        ld595_en,
    output logic [31:0] din0,
    output logic [31:0] din1,
    output logic [31:0] din2,
    output logic [31:0] din3,
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);

    localparam int WW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int AW = (ARM_CYC < 2) ? 1 : $clog2(ARM_CYC);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC);
    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_CYC - 1);

    typedef enum logic [2:0] {IDLE, ARM, GO, REL, NEXT, FIN} state_t;

    state_t          state_q;
    logic            phase595_q;
    logic [AW-1:0]   arm_cnt_q;
    logic [WW-1:0]   wait_cnt_q;
    logic            start_q;
    logic            ld1595_q;
    logic            ld595_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [127:0]    din_q;

    // Active sequence capture
    logic [1:0]      cap_mode_q;
    logic [127:0]    cap_dac_q;
    logic [63:0]     cap_rly_q;

    // One-deep pending request
    logic            pend_q;
    logic [1:0]      pend_mode_q;
    logic [127:0]    pend_dac_q;
    logic [63:0]     pend_rly_q;

    logic            req_ok;
    logic            launch_ext;
    logic            launch_pend;
    logic            launch;
    logic            wait_expired;
    logic            pend_capture;
    logic [1:0]      launch_mode_d;
    logic [127:0]    launch_dac_d;
    logic [63:0]     launch_rly_d;
    logic [127:0]    launch_din_d;
    logic [127:0]    next_din_d;

    // Serializer word image: 1595 passes the DAC words, 595 spreads relay bytes
    function automatic logic [127:0] din_for(input logic p595, input logic [127:0] dac,
                                             input logic [63:0] rly);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (p595) begin
                r[32*k +: 32] = {rly[16*k + 8 +: 8], 8'h00, rly[16*k +: 8], 8'h00};
            end else begin
                r[32*k +: 32] = dac[32*k +: 32];
            end
        end
        return r;
    endfunction

    // Launch selection, timeout detection and pending-capture qualification
    always_comb begin
        req_ok        = req && (mode != 2'b00);
        launch_ext    = (state_q == IDLE) && !pend_q && req_ok;
        launch_pend   = ((state_q == IDLE) || (state_q == FIN)) && pend_q;
        launch        = launch_ext || launch_pend;
        launch_mode_d = pend_mode_q;
        launch_dac_d  = pend_dac_q;
        launch_rly_d  = pend_rly_q;
        if (launch_ext) begin
            launch_mode_d = mode;
            launch_dac_d  = {dac_in3, dac_in2, dac_in1, dac_in0};
            launch_rly_d  = rly_in;
        end
        launch_din_d  = din_for(!launch_mode_d[0], launch_dac_d, launch_rly_d);
        next_din_d    = din_for(1'b1, cap_dac_q, cap_rly_q);
        wait_expired  = (wait_cnt_q == WAIT_LAST) &&
                        (((state_q == GO) && !config_done) ||
                         ((state_q == REL) && config_done));
        pend_capture  = req_ok && !launch_ext && !wait_expired;
    end

    // Sequencer FSM with registered serializer controls and status
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= IDLE;
            phase595_q  <= 1'b0;
            arm_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            start_q     <= 1'b0;
            ld1595_q    <= 1'b0;
            ld595_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            din_q       <= '0;
            cap_mode_q  <= 2'b00;
            cap_dac_q   <= '0;
            cap_rly_q   <= '0;
            pend_q      <= 1'b0;
            pend_mode_q <= 2'b00;
            pend_dac_q  <= '0;
            pend_rly_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                state_q    <= ARM;
                busy_q     <= 1'b1;
                phase595_q <= !launch_mode_d[0];
                cap_mode_q <= launch_mode_d;
                cap_dac_q  <= launch_dac_d;
                cap_rly_q  <= launch_rly_d;
                din_q      <= launch_din_d;
                ld1595_q   <= launch_mode_d[0];
                ld595_q    <= !launch_mode_d[0];
                err_q      <= 1'b0;
                arm_cnt_q  <= '0;
                pend_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ARM: begin
                        if (arm_cnt_q == ARM_LAST) begin
                            state_q    <= GO;
                            start_q    <= 1'b1;
                            wait_cnt_q <= '0;
                        end else begin
                            arm_cnt_q <= arm_cnt_q + 1'b1;
                        end
                    end
                    GO, REL: begin
                        if (wait_expired) begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            start_q  <= 1'b0;
                            ld1595_q <= 1'b0;
                            ld595_q  <= 1'b0;
                            err_q    <= 1'b1;
                            pend_q   <= 1'b0;
                        end else if ((state_q == GO) && config_done) begin
                            state_q    <= REL;
                            start_q    <= 1'b0;
                            wait_cnt_q <= '0;
                        end else if ((state_q == REL) && !config_done) begin
                            state_q <= NEXT;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                    NEXT: begin
                        if (!phase595_q && (cap_mode_q == 2'b11)) begin
                            state_q    <= ARM;
                            phase595_q <= 1'b1;
                            din_q      <= next_din_d;
                            ld1595_q   <= 1'b0;
                            ld595_q    <= 1'b1;
                            arm_cnt_q  <= '0;
                        end else begin
                            state_q  <= FIN;
                            done_q   <= 1'b1;
                            ld1595_q <= 1'b0;
                            ld595_q  <= 1'b0;
                        end
                    end
                    FIN: begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        ld1595_q <= 1'b0;
                        ld595_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
            if (pend_capture) begin
                pend_q      <= 1'b1;
                pend_mode_q <= mode;
                pend_dac_q  <= {dac_in3, dac_in2, dac_in1, dac_in0};
                pend_rly_q  <= rly_in;
            end
        end
    end

    assign start       = start_q;
    assign ld1595_en   = ld1595_q;
    assign ld595_en    = ld595_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign din0        = din_q[31:0];
    assign din1        = din_q[63:32];
    assign din2        = din_q[95:64];
    assign din3        = din_q[127:96];

endmodule

// File: tb/tb_amp_cfg_scheduler.sv
// tb/tb_amp_cfg_scheduler.sv - randomized self-checking bench for amp_cfg_scheduler
module tb_amp_cfg_scheduler;

    logic        clkin = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] dac_in0 = '0, dac_in1 = '0, dac_in2 = '0, dac_in3 = '0;
    logic [63:0] rly_in = '0;
    logic        config_done = 1'b0;
    logic        start, ld1595_en, ld595_en, busy, done, err_timeout;
    logic [31:0] din0, din1, din2, din3;

    int tests_run = 0;
    int tests_failed = 0;

    amp_cfg_scheduler dut (
        .clkin(clkin), .rst(rst), .req(req), .mode(mode),
        .dac_in0(dac_in0), .dac_in1(dac_in1), .dac_in2(dac_in2), .dac_in3(dac_in3),
        .rly_in(rly_in), .config_done(config_done),
        .start(start), .ld1595_en(ld1595_en), .ld595_en(ld595_en),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #20 clkin = ~clkin;

    // Serializer model: raises config_done ser_delay cycles into start, drops it once start falls
    int ser_delay = 40;
    int ser_cnt = 0;
    bit ser_en = 1'b1;
    always @(negedge clkin) begin
        if (!ser_en || !start) begin
            config_done = 1'b0;
            ser_cnt = 0;
        end else if (ser_cnt >= ser_delay) begin
            config_done = 1'b1;
        end else begin
            ser_cnt = ser_cnt + 1;
        end
    end

    // Request injections keyed by cycle index within an observation window
    int           inj_t[$];
    logic [1:0]   inj_mode[$];
    logic [127:0] inj_dac[$];
    logic [63:0]  inj_rly[$];

    // Expected load phases: words presented to the serializer and which part they target
    logic [127:0] exp_din[$];
    bit           exp_595[$];

    // Observations
    int o_rises, o_first_rise, o_done, o_done_t, o_last_fall, o_min_gap;
    int o_unstable, o_both_en, o_err_t, o_busy_drops, o_high_cyc, o_ld1595_cyc;
    logic o_busy_s1, o_err_s1;
    logic [127:0] o_din[$];
    bit o_595[$];
    bit o_1595[$];

    function automatic void inject(input int t, input logic [1:0] m, input logic [127:0] d,
                                   input logic [63:0] r);
        inj_t.push_back(t);
        inj_mode.push_back(m);
        inj_dac.push_back(d);
        inj_rly.push_back(r);
    endfunction

    // Reference: each mode bit selects one load; the 595 load places relay byte i
    // in the upper byte of a 16-bit lane, lane i packed upward across din0..din3
    function automatic void exp_push(input logic [1:0] m, input logic [127:0] d,
                                     input logic [63:0] r);
        logic [127:0] w;
        logic [63:0]  b_lo, b_hi;
        if (m[0]) begin
            exp_din.push_back(d);
            exp_595.push_back(1'b0);
        end
        if (m[1]) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                b_lo = (r >> (16 * k)) & 64'hff;
                b_hi = (r >> (16 * k + 8)) & 64'hff;
                w = w | ({64'd0, (b_hi << 24) | (b_lo << 8)} << (32 * k));
            end
            exp_din.push_back(w);
            exp_595.push_back(1'b1);
        end
    endfunction

    task automatic observe(input int n);
        logic [127:0] cur, ref_din;
        logic [1:0]   ref_en;
        logic         prev_start, prev_busy;
        int           s;
        o_rises = 0; o_first_rise = -1; o_done = 0; o_done_t = -1; o_last_fall = -1;
        o_min_gap = 1000000; o_unstable = 0; o_both_en = 0; o_err_t = -1;
        o_busy_drops = 0; o_high_cyc = 0; o_ld1595_cyc = 0; o_busy_s1 = 1'b0; o_err_s1 = 1'b0;
        o_din.delete(); o_595.delete(); o_1595.delete();
        prev_start = start; prev_busy = busy; ref_din = '0; ref_en = 2'b00;
        for (int t = 0; t < n; t++) begin
            if (inj_t.size() > 0 && inj_t[0] == t) begin
                req = 1'b1;
                mode = inj_mode[0];
                {dac_in3, dac_in2, dac_in1, dac_in0} = inj_dac[0];
                rly_in = inj_rly[0];
                void'(inj_t.pop_front()); void'(inj_mode.pop_front());
                void'(inj_dac.pop_front()); void'(inj_rly.pop_front());
            end else begin
                req = 1'b0;
            end
            @(negedge clkin);
            s = t + 1;
            cur = {din3, din2, din1, din0};
            if (s == 1) begin
                o_busy_s1 = busy;
                o_err_s1 = err_timeout;
            end
            if (start && !prev_start) begin
                o_rises++;
                if (o_first_rise < 0) o_first_rise = s;
                if (o_last_fall >= 0 && (s - o_last_fall) < o_min_gap) o_min_gap = s - o_last_fall;
                o_din.push_back(cur);
                o_595.push_back(ld595_en);
                o_1595.push_back(ld1595_en);
                ref_din = cur;
                ref_en = {ld1595_en, ld595_en};
            end else if (start && (cur !== ref_din || {ld1595_en, ld595_en} !== ref_en)) begin
                o_unstable++;
            end
            if (!start && prev_start) o_last_fall = s;
            if (start) o_high_cyc++;
            if (done) begin o_done++; o_done_t = s; end
            if (ld1595_en && ld595_en) o_both_en++;
            if (ld1595_en) o_ld1595_cyc++;
            if (err_timeout && o_err_t < 0) o_err_t = s;
            if (prev_busy && !busy) o_busy_drops++;
            prev_start = start;
            prev_busy = busy;
        end
        req = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clkin);
        tests_run++;
        if ({start, busy, done, err_timeout, ld1595_en, ld595_en} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {start, busy, done, err_timeout, ld1595_en, ld595_en});
        end
        tests_run++;
        if ({din3, din2, din1, din0} !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_din: got %h expected 0", {din3, din2, din1, din0});
        end
        rst = 1'b0;
        @(negedge clkin);
    endtask

    task automatic test_mode01();
        logic [127:0] d;
        d = {rnd128()} & ~128'hffff_ffff | 128'h1234_5678;
        ser_delay = 40;
        exp_din.delete(); exp_595.delete();
        exp_push(2'b01, d, 64'd0);
        inject(0, 2'b01, d, 64'd0);
        observe(120);
        tests_run++;
        if (o_first_rise !== 3) begin
            tests_failed++; $display("FAIL m01_latency: got %0d expected 3", o_first_rise);
        end
        tests_run++;
        if (o_din.size() != 1 || o_din[0][31:0] !== 32'h1234_5678 || o_1595[0] !== 1'b1 || o_595[0] !== 1'b0) begin
            tests_failed++; $display("FAIL m01_load: got rises %0d expected 1 with din0 12345678", o_din.size());
        end else begin
            tests_run++;
            if (o_din[0] !== exp_din[0]) begin
                tests_failed++; $display("FAIL m01_din: got %h expected %h", o_din[0], exp_din[0]);
            end
        end
        tests_run++;
        if (o_done !== 1 || o_busy_s1 !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL m01_done: got done %0d busy_s1 %b expected 1 1", o_done, o_busy_s1);
        end
    endtask

    task automatic test_mode10();
        logic [63:0] r;
        r = {$urandom, 16'($urandom), 16'h0201};
        ser_delay = 25;
        inject(0, 2'b10, rnd128(), r);
        observe(100);
        tests_run++;
        if (o_din.size() != 1 || o_din[0][31:0] !== 32'h0200_0100 || o_595[0] !== 1'b1) begin
            tests_failed++; $display("FAIL m10_din0: got rises %0d expected din0 02000100 with ld595", o_din.size());
        end
        tests_run++;
        if (o_ld1595_cyc !== 0 || o_done !== 1) begin
            tests_failed++; $display("FAIL m10_en: got ld1595 cycles %0d done %0d expected 0 1", o_ld1595_cyc, o_done);
        end
    endtask

    task automatic test_mode11();
        logic [127:0] d;
        logic [63:0]  r;
        d = rnd128(); r = {$urandom, $urandom};
        ser_delay = 40;
        exp_din.delete(); exp_595.delete();
        exp_push(2'b11, d, r);
        inject(0, 2'b11, d, r);
        observe(150);
        tests_run++;
        if (o_rises !== 2 || o_done !== 1) begin
            tests_failed++; $display("FAIL m11_count: got rises %0d done %0d expected 2 1", o_rises, o_done);
        end
        for (int i = 0; i < exp_din.size(); i++) begin
            tests_run++;
            if (i >= o_din.size() || o_din[i] !== exp_din[i] || o_595[i] !== exp_595[i] || o_1595[i] !== !exp_595[i]) begin
                tests_failed++; $display("FAIL m11_phase%0d: got %h expected %h", i,
                                         (i < o_din.size()) ? o_din[i] : 128'd0, exp_din[i]);
            end
        end
        tests_run++;
        if (o_done_t <= o_last_fall || o_min_gap < 3 || o_unstable !== 0 || o_both_en !== 0) begin
            tests_failed++; $display("FAIL m11_order: got done_t %0d fall %0d gap %0d unstable %0d expected done after fall, gap>=3, 0",
                                     o_done_t, o_last_fall, o_min_gap, o_unstable);
        end
    endtask

    task automatic test_mode00();
        inject(0, 2'b00, rnd128(), 64'd0);
        observe(20);
        tests_run++;
        if (o_rises !== 0 || o_done !== 0 || o_busy_s1 !== 1'b0) begin
            tests_failed++; $display("FAIL m00_noop: got rises %0d done %0d busy %b expected 0 0 0", o_rises, o_done, o_busy_s1);
        end
    endtask

    task automatic test_timeout();
        ser_en = 1'b0;
        inject(0, 2'b01, rnd128(), 64'd0);
        inject(100, 2'b10, rnd128(), {$urandom, $urandom});
        observe(1080);
        tests_run++;
        if (o_err_t !== 1027 || o_high_cyc !== 1024) begin
            tests_failed++; $display("FAIL to_timing: got err at %0d high %0d expected 1027 1024", o_err_t, o_high_cyc);
        end
        tests_run++;
        if (o_done !== 0 || o_rises !== 1 || start !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b1) begin
            tests_failed++; $display("FAIL to_state: got done %0d rises %0d err %b expected 0 1 1", o_done, o_rises, err_timeout);
        end
        tests_run++;
        if ({ld1595_en, ld595_en} !== 2'b00) begin
            tests_failed++; $display("FAIL to_en: got %b expected 00", {ld1595_en, ld595_en});
        end
        ser_en = 1'b1;
        ser_delay = 10;
        inject(0, 2'b10, rnd128(), {$urandom, $urandom});
        observe(80);
        tests_run++;
        if (o_err_s1 !== 1'b0 || o_done !== 1) begin
            tests_failed++; $display("FAIL to_clear: got err %b done %0d expected 0 1", o_err_s1, o_done);
        end
    endtask

    task automatic test_pending();
        logic [127:0] da, db, dc;
        logic [63:0]  rb, rc;
        da = rnd128(); db = rnd128(); dc = rnd128();
        rb = {$urandom, $urandom}; rc = {$urandom, $urandom};
        ser_delay = 40;
        exp_din.delete(); exp_595.delete();
        exp_push(2'b01, da, 64'd0);
        exp_push(2'b11, dc, rc);
        inject(0, 2'b01, da, 64'd0);
        inject(10, 2'b10, db, rb);
        inject(20, 2'b11, dc, rc);
        observe(260);
        tests_run++;
        if (o_done !== 2 || o_busy_drops !== 1 || o_rises !== 3) begin
            tests_failed++; $display("FAIL pend_count: got done %0d busy_drops %0d rises %0d expected 2 1 3",
                                     o_done, o_busy_drops, o_rises);
        end
        for (int i = 0; i < exp_din.size(); i++) begin
            tests_run++;
            if (i >= o_din.size() || o_din[i] !== exp_din[i] || o_595[i] !== exp_595[i]) begin
                tests_failed++; $display("FAIL pend_phase%0d: got %h expected %h", i,
                                         (i < o_din.size()) ? o_din[i] : 128'd0, exp_din[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ser_delay = 40;
        inject(0, 2'b11, rnd128(), {$urandom, $urandom});
        inject(5, 2'b01, rnd128(), 64'd0);
        observe(10);
        tests_run++;
        if (start !== 1'b1) begin
            tests_failed++; $display("FAIL rst_pre: got start %b expected 1", start);
        end
        rst = 1'b1;
        @(negedge clkin);
        tests_run++;
        if ({start, busy, done, err_timeout, ld1595_en, ld595_en} !== 6'b0 || {din3, din2, din1, din0} !== 128'd0) begin
            tests_failed++; $display("FAIL rst_mid: got %b din %h expected all zero",
                                     {start, busy, done, err_timeout, ld1595_en, ld595_en}, {din3, din2, din1, din0});
        end
        rst = 1'b0;
        observe(100);
        tests_run++;
        if (o_rises !== 0 || o_done !== 0) begin
            tests_failed++; $display("FAIL rst_pend: got rises %0d done %0d expected 0 0", o_rises, o_done);
        end
    endtask

    task automatic test_random();
        logic [127:0] d1, d2;
        logic [63:0]  r1, r2;
        logic [1:0]   m1, m2;
        bit           two;
        for (int it = 0; it < 10; it++) begin
            d1 = rnd128(); d2 = rnd128();
            r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
            m1 = 2'($urandom_range(1, 3)); m2 = 2'($urandom_range(1, 3));
            two = 1'($urandom_range(0, 1));
            ser_delay = $urandom_range(1, 30);
            exp_din.delete(); exp_595.delete();
            exp_push(m1, d1, r1);
            inject(0, m1, d1, r1);
            if (two) begin
                exp_push(m2, d2, r2);
                inject(8, m2, d2, r2);
            end
            observe(220);
            tests_run++;
            if (o_done !== (two ? 2 : 1) || o_rises !== exp_din.size() || busy !== 1'b0) begin
                tests_failed++; $display("FAIL rand%0d_count: got done %0d rises %0d expected %0d %0d",
                                         it, o_done, o_rises, two ? 2 : 1, exp_din.size());
            end
            for (int i = 0; i < exp_din.size(); i++) begin
                tests_run++;
                if (i >= o_din.size() || o_din[i] !== exp_din[i] || o_595[i] !== exp_595[i] || o_1595[i] !== !exp_595[i]) begin
                    tests_failed++; $display("FAIL rand%0d_phase%0d: got %h expected %h", it, i,
                                             (i < o_din.size()) ? o_din[i] : 128'd0, exp_din[i]);
                end
            end
            tests_run++;
            if (o_unstable !== 0 || o_both_en !== 0 || (o_rises > 1 && o_min_gap < 3)) begin
                tests_failed++; $display("FAIL rand%0d_rules: got unstable %0d both %0d gap %0d expected 0 0 >=3",
                                         it, o_unstable, o_both_en, o_min_gap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode01();
        test_mode10();
        test_mode11();
        test_mode00();
        test_timeout();
        test_pending();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
